// File: rtl/sample_framer_pkg.sv
// Shared constants and state encoding for the sample framer and the
// averager datapath that consumes its frames.
package sample_framer_pkg;

    // Samples per frame (fixed) and the widths derived from it.
    localparam int NSAMP      = 8;
    localparam int LANE_IDX_W = 3;
    localparam int COUNT_W    = 4;
    localparam int SA_W       = 8;

    // FILL collects samples; HOLD presents a full frame downstream.
    typedef enum logic {
        FILL = 1'b0,
        HOLD = 1'b1
    } framer_state_t;

endpackage

// File: rtl/sample_framer_lane_reg.sv
// One frame lane: a plain data register with write enable and sync reset.
module lane_reg
    import sample_framer_pkg::*;
#(
    parameter int DATAWIDTH = 16
) (
    input  logic                 Clk,
    input  logic                 Rst,
    input  logic                 we,
    input  logic [DATAWIDTH-1:0] d,
    output logic [DATAWIDTH-1:0] q
);

    // Hold the last written sample; only a write or reset changes it.
    always_ff @(posedge Clk) begin
        if (Rst)
            q <= '0;
        else if (we)
            q <= d;
    end

endmodule

// File: rtl/sample_framer.sv
// Collects 8 serial samples into a parallel frame and holds it, together
// with the shift amount captured on the last sample, until the downstream
// averager takes it.
module sample_framer
    import sample_framer_pkg::*;
#(
    parameter int DATAWIDTH = 16,
    parameter int NSAMP     = 8
) (
    input  logic                   Clk,
    input  logic                   Rst,
    input  logic [DATAWIDTH-1:0]   in_data,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic                   flush,
    input  logic [SA_W-1:0]        sa_in,
    input  logic                   sa_load,
    output logic [8*DATAWIDTH-1:0] frame,
    output logic [SA_W-1:0]        sa_out,
    output logic                   frame_valid,
    input  logic                   frame_ready,
    output logic [COUNT_W-1:0]     count
);

    localparam logic [COUNT_W-1:0] FULL_COUNT = COUNT_W'(NSAMP);

    framer_state_t      state;
    logic [SA_W-1:0]    sa_reg;
    logic [COUNT_W-1:0] count_nxt;
    logic               xfer;
    logic [NSAMP-1:0]   lane_we;

    // A flush in the same cycle wins over the transfer and drops the sample.
    assign xfer      = in_valid && in_ready && !flush;
    assign count_nxt = count + COUNT_W'(1);

    // One register per lane; the lane selected by count takes the sample.
    for (genvar k = 0; k < NSAMP; k++) begin : g_lane
        assign lane_we[k] = xfer && (count[LANE_IDX_W-1:0] == LANE_IDX_W'(k));

        lane_reg #(
            .DATAWIDTH (DATAWIDTH)
        ) u_lane (
            .Clk (Clk),
            .Rst (Rst),
            .we  (lane_we[k]),
            .d   (in_data),
            .q   (frame[k*DATAWIDTH +: DATAWIDTH])
        );
    end

    // FILL/HOLD control with registered handshake outputs and sa capture.
    always_ff @(posedge Clk) begin
        if (Rst) begin
            state       <= FILL;
            count       <= '0;
            in_ready    <= 1'b1;
            frame_valid <= 1'b0;
            sa_reg      <= '0;
            sa_out      <= '0;
        end else begin
            if (sa_load)
                sa_reg <= sa_in;
            case (state)
                FILL: begin
                    if (flush) begin
                        count <= '0;
                    end else if (xfer) begin
                        count <= count_nxt;
                        if (count_nxt == FULL_COUNT) begin
                            state       <= HOLD;
                            in_ready    <= 1'b0;
                            frame_valid <= 1'b1;
                            // A load in the closing cycle is what the frame reports.
                            sa_out      <= sa_load ? sa_in : sa_reg;
                        end
                    end
                end
                HOLD: begin
                    if (frame_ready) begin
                        state       <= FILL;
                        count       <= '0;
                        in_ready    <= 1'b1;
                        frame_valid <= 1'b0;
                    end
                end
            endcase
        end
    end

endmodule
